// File: rtl/aes_ti_pkg.sv
// rtl/aes_ti_pkg.sv - shared constants and types for the threshold AES datapath
package aes_ti_pkg;

    localparam int NBYTES       = 16;
    localparam int SBOX_LATENCY = 4;
    localparam int IDX_W        = $clog2(NBYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sbs_state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/masked_tag_pipe.sv
// rtl/masked_tag_pipe.sv - valid+index shift register tracking bytes in flight through the S-box
module masked_tag_pipe #(
    parameter int LATENCY = 4,
    parameter int IDX_W   = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    logic [LATENCY-1:0]            valid_q, valid_d;
    logic [LATENCY-1:0][IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        valid_d    = '0;
        idx_d      = '0;
        valid_d[0] = in_valid;
        idx_d[0]   = in_idx;
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            idx_d[i]   = idx_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            valid_q <= '0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_idx   = idx_q[LATENCY-1];

endmodule

// File: rtl/masked_subbytes_seq.sv
// rtl/masked_subbytes_seq.sv - serialises a two-share state through the pipelined masked S-box
module masked_subbytes_seq #(
    parameter int NBYTES  = aes_ti_pkg::NBYTES,
    parameter int LATENCY = aes_ti_pkg::SBOX_LATENCY
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic [NBYTES*8-1:0] state_in0,
    input  logic [NBYTES*8-1:0] state_in1,
    input  logic [7:0]          rnd_in0,
    input  logic [7:0]          rnd_in1,
    input  logic                rnd_valid,
    output logic [7:0]          sbox_in0,
    output logic [7:0]          sbox_in1,
    output logic [7:0]          sbox_ran0,
    output logic [7:0]          sbox_ran1,
    input  logic [7:0]          sbox_out0,
    input  logic [7:0]          sbox_out1,
    output logic [NBYTES*8-1:0] state_out0,
    output logic [NBYTES*8-1:0] state_out1,
    output logic                busy,
    output logic                done
);

    import aes_ti_pkg::sbs_state_e, aes_ti_pkg::ST_IDLE, aes_ti_pkg::ST_ISSUE,
           aes_ti_pkg::ST_DRAIN, aes_ti_pkg::ST_DONE;

    localparam int               CNT_W    = $clog2(NBYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);
    localparam logic [CNT_W:0]   CAP_ALL  = (CNT_W + 1)'(NBYTES);

    sbs_state_e          state_q, state_d;
    logic [NBYTES*8-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic [NBYTES*8-1:0] out0_q, out0_d, out1_q, out1_d;
    logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
    logic [CNT_W:0]      cap_cnt_q, cap_cnt_d;
    logic                issue_fire, cap_fire, tag_valid;
    logic [CNT_W-1:0]    tag_idx;

    assign issue_fire = (state_q == ST_ISSUE) && rnd_valid;
    assign cap_fire   = tag_valid && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));

    // Bubbles are pushed as invalid tags so each result lines up with its issue slot
    masked_tag_pipe #(
        .LATENCY (LATENCY),
        .IDX_W   (CNT_W)
    ) u_tag_pipe (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (issue_fire),
        .in_idx    (issue_cnt_q),
        .out_valid (tag_valid),
        .out_idx   (tag_idx)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_ISSUE;
            ST_ISSUE: if (issue_fire && (issue_cnt_q == LAST_IDX)) state_d = ST_DRAIN;
            ST_DRAIN: if (cap_cnt_d == CAP_ALL) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Issue path stays combinational so the S-box sees the byte in its issue cycle
    always_comb begin
        busy      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
        done      = (state_q == ST_DONE);
        sbox_in0  = '0;
        sbox_in1  = '0;
        sbox_ran0 = '0;
        sbox_ran1 = '0;
        if (issue_fire) begin
            sbox_in0  = buf0_q[{issue_cnt_q, 3'b000} +: 8];
            sbox_in1  = buf1_q[{issue_cnt_q, 3'b000} +: 8];
            sbox_ran0 = rnd_in0;
            sbox_ran1 = rnd_in1;
        end
    end

    always_comb begin
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        out0_d      = out0_q;
        out1_d      = out1_q;
        issue_cnt_d = issue_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        if ((state_q == ST_IDLE) && start) begin
            buf0_d      = state_in0;
            buf1_d      = state_in1;
            issue_cnt_d = '0;
            cap_cnt_d   = '0;
        end
        if (issue_fire) begin
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
        end
        if (cap_fire) begin
            out0_d[{tag_idx, 3'b000} +: 8] = sbox_out0;
            out1_d[{tag_idx, 3'b000} +: 8] = sbox_out1;
            cap_cnt_d = cap_cnt_q + (CNT_W + 1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            buf0_q      <= '0;
            buf1_q      <= '0;
            out0_q      <= '0;
            out1_q      <= '0;
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
        end else begin
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            out0_q      <= out0_d;
            out1_q      <= out1_d;
            issue_cnt_q <= issue_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
        end
    end

    assign state_out0 = out0_q;
    assign state_out1 = out1_q;

endmodule
